cpu_ctrl_unit: RTL and testbench

Multi-cycle control sequencer that drives every load/read/write strobe of CPU_datapath. It consumes the datapath's opcode, operand fields and ALU flags. It owns the instruction-level FSM (fetch, dispatch, execute) and issues one control word per clock to the datapath's control inputs.

---
 rtl/cpu_ctrl_pkg.sv | 66 ++++++
 rtl/cpu_ctrl_decode.sv | 75 +++++++
 rtl/cpu_ctrl_unit.sv | 127 ++++++++++++
 tb/tb_cpu_ctrl_unit.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the CPU control sequencer: state encoding,
// opcodes, control-word bit positions and ALU function selects.
package cpu_ctrl_pkg;

    localparam int unsigned CTRL_W  = 21;
    localparam int unsigned STATE_W = 5;
    localparam int unsigned OPC_W   = 7;
    localparam int unsigned OPD_W   = 3;
    localparam int unsigned FSEL_W  = 3;
    localparam int unsigned FLAG_W  = 4;
    localparam int unsigned RET_W   = 16;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE, ST_F0, ST_F1, ST_F2, ST_D,
        ST_A0, ST_A1,
        ST_L0, ST_L1, ST_L2, ST_L3,
        ST_S0, ST_S1, ST_S2,
        ST_B0, ST_HALT
    } state_e;

    localparam logic [OPC_W-1:0] OPC_ADD  = 7'd0;
    localparam logic [OPC_W-1:0] OPC_SUB  = 7'd1;
    localparam logic [OPC_W-1:0] OPC_AND  = 7'd2;
    localparam logic [OPC_W-1:0] OPC_OR   = 7'd3;
    localparam logic [OPC_W-1:0] OPC_NEG  = 7'd4;
    localparam logic [OPC_W-1:0] OPC_MOV  = 7'd6;
    localparam logic [OPC_W-1:0] OPC_LD   = 7'd8;
    localparam logic [OPC_W-1:0] OPC_ST   = 7'd9;
    localparam logic [OPC_W-1:0] OPC_BZ   = 7'd10;
    localparam logic [OPC_W-1:0] OPC_HALT = 7'h7F;

    // Control-word bit positions, LSB first
    localparam int unsigned CB_LDPC      = 0;
    localparam int unsigned CB_LDIR      = 1;
    localparam int unsigned CB_LDMAR     = 2;
    localparam int unsigned CB_RDMEM     = 3;
    localparam int unsigned CB_WRMEM     = 4;
    localparam int unsigned CB_LDTMP     = 5;
    localparam int unsigned CB_LDMDRZ    = 6;
    localparam int unsigned CB_LDMDRDATA = 7;
    localparam int unsigned CB_WRREG     = 8;
    localparam int unsigned CB_RDREG     = 9;
    localparam int unsigned CB_LDALU     = 10;
    localparam int unsigned CB_LDXPC     = 11;
    localparam int unsigned CB_LDYPC     = 12;
    localparam int unsigned CB_LDXTMP    = 13;
    localparam int unsigned CB_LDYTMP    = 14;
    localparam int unsigned CB_LDXREG    = 15;
    localparam int unsigned CB_LDYREG    = 16;
    localparam int unsigned CB_LDXMEM    = 17;
    localparam int unsigned CB_LDYMEM    = 18;
    localparam int unsigned CB_LDXTMP2   = 19;
    localparam int unsigned CB_LDYTMP2   = 20;

    localparam logic [FSEL_W-1:0] FSEL_ADD   = 3'd0;
    localparam logic [FSEL_W-1:0] FSEL_SUB   = 3'd1;
    localparam logic [FSEL_W-1:0] FSEL_AND   = 3'd2;
    localparam logic [FSEL_W-1:0] FSEL_OR    = 3'd3;
    localparam logic [FSEL_W-1:0] FSEL_NEG   = 3'd4;
    localparam logic [FSEL_W-1:0] FSEL_PASSX = 3'd6;

    function automatic logic [CTRL_W-1:0] cbit(input int unsigned idx);
        return CTRL_W'(1) << idx;
    endfunction

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Combinational Moore decode: current state plus IR fields to the datapath
// control word, register-bank addresses and ALU function select.
module cpu_ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [STATE_W-1:0] state_i,
    input  logic [FSEL_W-1:0]  opc_lo_i,
    input  logic [OPD_W-1:0]   opd1_i,
    input  logic [OPD_W-1:0]   opd2_i,
    input  logic [OPD_W-1:0]   opd3_i,
    input  logic               zflag_i,
    output logic [CTRL_W-1:0]  ctrl_o,
    output logic [OPD_W-1:0]   wr_rega_o,
    output logic [OPD_W-1:0]   rd_rega_o,
    output logic [FSEL_W-1:0]  fsel_o
);

    state_e st;
    assign st = state_e'(state_i);

    always_comb begin
        ctrl_o    = '0;
        wr_rega_o = '0;
        rd_rega_o = '0;
        fsel_o    = '0;
        case (st)
            ST_F0: begin
                ctrl_o = cbit(CB_LDXPC) | cbit(CB_LDALU) | cbit(CB_LDMAR);
                fsel_o = FSEL_PASSX;
            end
            ST_F1: ctrl_o = cbit(CB_RDMEM) | cbit(CB_LDYTMP2);
            ST_F2: begin
                ctrl_o = cbit(CB_LDIR) | cbit(CB_LDXPC) | cbit(CB_LDALU) | cbit(CB_LDPC);
                fsel_o = FSEL_ADD;
            end
            ST_A0: begin
                ctrl_o    = cbit(CB_RDREG) | cbit(CB_LDYREG);
                rd_rega_o = opd3_i;
            end
            ST_A1: begin
                ctrl_o    = cbit(CB_RDREG) | cbit(CB_LDXREG) | cbit(CB_LDALU) | cbit(CB_WRREG);
                rd_rega_o = opd2_i;
                wr_rega_o = opd1_i;
                fsel_o    = opc_lo_i;
            end
            // LD and ST both start by moving R[opd2] into MAR
            ST_L0, ST_S0: begin
                ctrl_o    = cbit(CB_RDREG) | cbit(CB_LDXREG) | cbit(CB_LDALU) | cbit(CB_LDMAR);
                rd_rega_o = opd2_i;
                fsel_o    = FSEL_PASSX;
            end
            ST_L1: ctrl_o = cbit(CB_RDMEM);
            ST_L2: ctrl_o = cbit(CB_LDMDRDATA);
            ST_L3: begin
                ctrl_o    = cbit(CB_LDXMEM) | cbit(CB_LDALU) | cbit(CB_WRREG);
                wr_rega_o = opd1_i;
                fsel_o    = FSEL_PASSX;
            end
            ST_S1: begin
                ctrl_o    = cbit(CB_RDREG) | cbit(CB_LDXREG) | cbit(CB_LDALU) | cbit(CB_LDMDRZ);
                rd_rega_o = opd1_i;
                fsel_o    = FSEL_PASSX;
            end
            ST_S2: ctrl_o = cbit(CB_WRMEM);
            ST_B0: begin
                ctrl_o    = cbit(CB_RDREG) | cbit(CB_LDXREG) | cbit(CB_LDALU)
                          | (zflag_i ? cbit(CB_LDPC) : '0);
                rd_rega_o = opd1_i;
                fsel_o    = FSEL_PASSX;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_ctrl_unit.sv
// Multi-cycle instruction sequencer driving the CPU datapath strobes.
// Optional retired-instruction counter enabled by CPU_CTRL_RETIRE_CNT_EN.
module cpu_ctrl_unit
    import cpu_ctrl_pkg::*;
#(
    parameter logic [OPC_W-1:0] HALT_OPC = OPC_HALT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic [OPC_W-1:0]  opc,
    input  logic [OPD_W-1:0]  opd1,
    input  logic [OPD_W-1:0]  opd2,
    input  logic [OPD_W-1:0]  opd3,
    input  logic              C,
    input  logic              V,
    input  logic              S,
    input  logic              Z_det,
    output logic [CTRL_W-1:0] ctrl,
    output logic [OPD_W-1:0]  wr_regA,
    output logic [OPD_W-1:0]  rd_regA,
    output logic [FSEL_W-1:0] fsel,
    output logic [FLAG_W-1:0] flags,
    output logic              halted,
    output logic              illegal
`ifdef CPU_CTRL_RETIRE_CNT_EN
    ,
    output logic [RET_W-1:0]  retired
`endif
);

    state_e             state_q, state_d;
    logic [FLAG_W-1:0]  flags_q, flags_d;
    logic               illegal_q, illegal_d;
    logic               halted_q;
    logic               complete_c;

    // Next-state, flag latch and completion decision
    always_comb begin
        state_d    = state_q;
        flags_d    = flags_q;
        illegal_d  = illegal_q;
        complete_c = 1'b0;
        case (state_q)
            ST_IDLE: if (run) state_d = ST_F0;
            ST_F0:   state_d = ST_F1;
            ST_F1:   state_d = ST_F2;
            ST_F2:   state_d = ST_D;
            ST_D: begin
                if (opc == HALT_OPC) begin
                    state_d = ST_HALT;
                end else begin
                    case (opc)
                        OPC_ADD, OPC_SUB, OPC_AND, OPC_OR: state_d = ST_A0;
                        OPC_NEG, OPC_MOV:                  state_d = ST_A1;
                        OPC_LD:                            state_d = ST_L0;
                        OPC_ST:                            state_d = ST_S0;
                        OPC_BZ:                            state_d = ST_B0;
                        default: begin
                            illegal_d  = 1'b1;
                            complete_c = 1'b1;
                        end
                    endcase
                end
            end
            ST_A0:   state_d = ST_A1;
            ST_A1: begin
                complete_c = 1'b1;
                if (opc <= OPC_NEG) flags_d = {C, V, S, Z_det};
            end
            ST_L0:   state_d = ST_L1;
            ST_L1:   state_d = ST_L2;
            ST_L2:   state_d = ST_L3;
            ST_L3:   complete_c = 1'b1;
            ST_S0:   state_d = ST_S1;
            ST_S1:   state_d = ST_S2;
            ST_S2:   complete_c = 1'b1;
            ST_B0:   complete_c = 1'b1;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
        if (complete_c) state_d = run ? ST_F0 : ST_IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            flags_q   <= '0;
            illegal_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            flags_q   <= flags_d;
            illegal_q <= illegal_d;
            halted_q  <= (state_d == ST_HALT);
        end
    end

`ifdef CPU_CTRL_RETIRE_CNT_EN
    logic [RET_W-1:0] retired_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)          retired_q <= '0;
        else if (complete_c) retired_q <= retired_q + RET_W'(1);
    end

    assign retired = retired_q;
`endif

    cpu_ctrl_decode u_decode (
        .state_i   (state_q),
        .opc_lo_i  (opc[FSEL_W-1:0]),
        .opd1_i    (opd1),
        .opd2_i    (opd2),
        .opd3_i    (opd3),
        .zflag_i   (flags_q[0]),
        .ctrl_o    (ctrl),
        .wr_rega_o (wr_regA),
        .rd_rega_o (rd_regA),
        .fsel_o    (fsel)
    );

    assign flags   = flags_q;
    assign illegal = illegal_q;
    assign halted  = halted_q;

endmodule

// File: tb/tb_cpu_ctrl_unit.sv
// Randomized bench for cpu_ctrl_unit: an instruction-level model expands each
// instruction into its expected per-cycle control words and tracks flag/sticky state.
module tb_cpu_ctrl_unit;

    localparam int CW = 21;
    localparam int B_LDPC = 0, B_LDIR = 1, B_LDMAR = 2, B_RDMEM = 3, B_WRMEM = 4;
    localparam int B_MDRZ = 6, B_MDRDATA = 7, B_WRREG = 8, B_RDREG = 9, B_LDALU = 10;
    localparam int B_XPC = 11, B_XREG = 15, B_YREG = 16, B_XMEM = 17, B_YTMP2 = 20;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          run;
    logic [6:0]    opc;
    logic [2:0]    opd1, opd2, opd3;
    logic          c_f, v_f, s_f, z_f;
    logic [CW-1:0] ctrl;
    logic [2:0]    wr_rega, rd_rega, fsel;
    logic [3:0]    flags;
    logic          halted, illegal;
`ifdef CPU_CTRL_RETIRE_CNT_EN
    logic [15:0]   retired;
`endif

    cpu_ctrl_unit dut (
        .clk(clk), .reset(rst_n), .run(run), .opc(opc),
        .opd1(opd1), .opd2(opd2), .opd3(opd3),
        .C(c_f), .V(v_f), .S(s_f), .Z_det(z_f),
        .ctrl(ctrl), .wr_regA(wr_rega), .rd_regA(rd_rega), .fsel(fsel),
        .flags(flags), .halted(halted), .illegal(illegal)
`ifdef CPU_CTRL_RETIRE_CNT_EN
        , .retired(retired)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string         name;
        logic [CW-1:0] ctrl;
        bit            fc; logic [2:0] fs;
        bit            rc; logic [2:0] ra;
        bit            wc; logic [2:0] wa;
    } step_t;

    step_t      seq[$];
    int         idx;
    int         mode;        // 0 idle, 1 executing, 2 halted
    logic [3:0] m_flags;
    bit         m_illegal;
    int         m_retired;
    logic [6:0] i_opc;
    logic [2:0] i_opd1, i_opd2, i_opd3;
    int         n_started;
    bit         force_halt;
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [CW-1:0] b(input int i);
        logic [CW-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic step_t mk(input string n, input logic [CW-1:0] c,
                                 input int fs = -1, input int ra = -1, input int wa = -1);
        step_t s;
        s.name = n; s.ctrl = c;
        s.fc = (fs >= 0); s.fs = 3'(fs);
        s.rc = (ra >= 0); s.ra = 3'(ra);
        s.wc = (wa >= 0); s.wa = 3'(wa);
        return s;
    endfunction

    function automatic bit is_legal(input logic [6:0] o);
        return (o <= 7'd4) || o == 7'd6 || o == 7'd8 || o == 7'd9 || o == 7'd10;
    endfunction

    // Pick the next instruction and expand it into its microsequence
    task automatic start_instr();
        int k;
        k = $urandom_range(0, 13);
        case (k)
            0, 1, 2, 3, 4: i_opc = 7'(k);
            5:  i_opc = 7'd6;
            6, 7: i_opc = 7'd8;
            8:  i_opc = 7'd9;
            9, 10: i_opc = 7'd10;
            11: i_opc = 7'($urandom_range(11, 126));
            12: i_opc = ($urandom_range(0, 1) == 0) ? 7'd5 : 7'd7;
            default: i_opc = 7'($urandom_range(0, 3));
        endcase
        if (force_halt) i_opc = 7'h7F;
        i_opd1 = 3'($urandom); i_opd2 = 3'($urandom); i_opd3 = 3'($urandom);
        n_started++;
        seq.delete();
        idx = 0;
        seq.push_back(mk("F0", b(B_XPC) | b(B_LDALU) | b(B_LDMAR), 6));
        seq.push_back(mk("F1", b(B_RDMEM) | b(B_YTMP2)));
        seq.push_back(mk("F2", b(B_LDIR) | b(B_XPC) | b(B_LDALU) | b(B_LDPC), 0));
        seq.push_back(mk("D", '0));
        if (i_opc <= 7'd3)
            seq.push_back(mk("A0", b(B_RDREG) | b(B_YREG), -1, int'(i_opd3)));
        if (i_opc <= 7'd4 || i_opc == 7'd6)
            seq.push_back(mk("A1", b(B_RDREG) | b(B_XREG) | b(B_LDALU) | b(B_WRREG),
                             int'(i_opc[2:0]), int'(i_opd2), int'(i_opd1)));
        if (i_opc == 7'd8 || i_opc == 7'd9)
            seq.push_back(mk(i_opc == 7'd8 ? "L0" : "S0",
                             b(B_RDREG) | b(B_XREG) | b(B_LDALU) | b(B_LDMAR), 6, int'(i_opd2)));
        if (i_opc == 7'd8) begin
            seq.push_back(mk("L1", b(B_RDMEM)));
            seq.push_back(mk("L2", b(B_MDRDATA)));
            seq.push_back(mk("L3", b(B_XMEM) | b(B_LDALU) | b(B_WRREG), 6, -1, int'(i_opd1)));
        end
        if (i_opc == 7'd9) begin
            seq.push_back(mk("S1", b(B_RDREG) | b(B_XREG) | b(B_LDALU) | b(B_MDRZ), 6, int'(i_opd1)));
            seq.push_back(mk("S2", b(B_WRMEM)));
        end
        if (i_opc == 7'd10)
            seq.push_back(mk("B0", b(B_RDREG) | b(B_XREG) | b(B_LDALU) | (m_flags[0] ? b(B_LDPC) : '0),
                             6, int'(i_opd1)));
        mode = 1;
    endtask

    task automatic model_reset();
        mode = 0; m_flags = '0; m_illegal = 0; m_retired = 0; seq.delete(); idx = 0;
    endtask

    // Advance the model by one clock using the inputs that were applied
    task automatic model_edge(input bit run_s, input logic [3:0] fl_s);
        if (mode == 0) begin
            if (run_s) start_instr();
        end else if (mode == 1) begin
            if (idx == seq.size() - 1) begin
                if (i_opc == 7'h7F) begin
                    mode = 2;
                end else begin
                    if (!is_legal(i_opc)) m_illegal = 1;
                    if (i_opc <= 7'd4) m_flags = fl_s;
                    m_retired = (m_retired + 1) & 16'hFFFF;
                    if (run_s) start_instr(); else mode = 0;
                end
            end else begin
                idx++;
            end
        end
    endtask

    task automatic check_outputs();
        if (mode == 1) begin
            chk({seq[idx].name, "_ctrl"}, 32'(ctrl), 32'(seq[idx].ctrl));
            if (seq[idx].fc) chk({seq[idx].name, "_fsel"}, 32'(fsel), 32'(seq[idx].fs));
            if (seq[idx].rc) chk({seq[idx].name, "_rdA"}, 32'(rd_rega), 32'(seq[idx].ra));
            if (seq[idx].wc) chk({seq[idx].name, "_wrA"}, 32'(wr_rega), 32'(seq[idx].wa));
        end else begin
            chk(mode == 2 ? "halt_ctrl" : "idle_ctrl", 32'(ctrl), 32'd0);
        end
        chk("flags", 32'(flags), 32'(m_flags));
        chk("halted", 32'(halted), 32'(mode == 2));
        chk("illegal", 32'(illegal), 32'(m_illegal));
`ifdef CPU_CTRL_RETIRE_CNT_EN
        chk("retired", 32'(retired), 32'(m_retired));
`endif
    endtask

    // run_mode: 0 random, 1 force low, 2 force high
    task automatic cycle(input int run_mode);
        @(negedge clk);
        case (run_mode)
            1: run = 1'b0;
            2: run = 1'b1;
            default: run = ($urandom_range(0, 4) != 0);
        endcase
        {c_f, v_f, s_f, z_f} = 4'($urandom);
        opc = i_opc; opd1 = i_opd1; opd2 = i_opd2; opd3 = i_opd3;
        #1;
        check_outputs();
        @(posedge clk);
        model_edge(run, {c_f, v_f, s_f, z_f});
    endtask

    // Asynchronous reset applied mid-cycle: strobes must drop at once
    task automatic async_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        run = 1'b0;
        #1;
        chk("rst_ctrl", 32'(ctrl), 32'd0);
        chk("rst_flags", 32'(flags), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) cycle(1);
    endtask

    initial begin
        bit mid_done;
        int guard;
        rst_n = 1'b0; run = 1'b0; opc = '0; opd1 = '0; opd2 = '0; opd3 = '0;
        {c_f, v_f, s_f, z_f} = '0;
        i_opc = '0; i_opd1 = '0; i_opd2 = '0; i_opd3 = '0;
        model_reset();
        repeat (2) @(posedge clk);
        for (int ep = 0; ep < 3; ep++) begin
            async_reset();
            n_started = 0;
            force_halt = 0;
            mid_done = (ep != 1);
            guard = 0;
            while (mode != 2 && guard < 5000) begin
                if (!mid_done && n_started > 5 && mode == 1 && seq[idx].name == "A1") begin
                    async_reset();
                    mid_done = 1;
                end else begin
                    cycle(0);
                end
                if (n_started >= 60) force_halt = 1;
                guard++;
            end
            chk("halt_reached", 32'(mode == 2), 32'd1);
            repeat (20) cycle(2);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
